// File: rtl/display_fifo.sv
// display_fifo: byte FIFO between the CPU terminal port and the VGA text controller, paced by the
// display ready handshake, with a cursor column shadow. Tab expansion is built under DISPLAY_FIFO_TAB_EN.
module display_fifo #(
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       write_in,
  output logic       full_out,
  output logic       empty_out,
  output logic [6:0] disp_data_out,
  output logic       disp_write_out,
  input  logic       disp_ready_in
);

  localparam int unsigned DEPTH   = 1 << DEPTH_BITS;
  localparam int unsigned CNT_W   = DEPTH_BITS + 1;
  localparam int unsigned COL_W   = 7;
  localparam logic [COL_W-1:0] COL_MAX = 7'd79;

  localparam logic [6:0] CH_NUL = 7'h00;
  localparam logic [6:0] CH_BS  = 7'h08;
  localparam logic [6:0] CH_LF  = 7'h0A;
  localparam logic [6:0] CH_CR  = 7'h0D;
`ifdef DISPLAY_FIFO_TAB_EN
  localparam int unsigned PEND_W = 4;
  localparam logic [6:0] CH_TAB = 7'h09;
  localparam logic [6:0] CH_SP  = 7'h20;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [6:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic [COL_W-1:0]      col;
  state_t                state;

  logic       push_c;
  logic       pop_c;
  logic       issue_c;
  logic [6:0] issue_ch_c;
  logic [6:0] head_c;
  logic       unused_bit7;

`ifdef DISPLAY_FIFO_TAB_EN
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_nxt;
  logic [PEND_W-1:0] tab_step_c;
  logic [COL_W-1:0]  tab_room_c;
  logic [PEND_W-1:0] tab_load_c;
`endif

  // Bit 7 of the CPU byte carries no meaning for the display.
  assign unused_bit7 = data_in[7];
  assign head_c      = mem[rd_ptr];

  // Cursor column after the display receives character ch.
  function automatic logic [COL_W-1:0] col_after(input logic [COL_W-1:0] c, input logic [6:0] ch);
    logic [COL_W-1:0] r;
    case (ch)
      CH_CR:   r = '0;
      CH_BS:   r = (c != '0) ? COL_W'(c - 7'd1) : c;
      CH_LF:   r = c;
      default: r = (c >= COL_MAX) ? COL_MAX : COL_W'(c + 7'd1);
    endcase
    return r;
  endfunction

`ifdef DISPLAY_FIFO_TAB_EN
  // Spaces to the next 8-column stop, never running past the last column.
  always_comb begin
    tab_step_c = PEND_W'(4'd8 - {1'b0, col[2:0]});
    tab_room_c = COL_W'(COL_MAX - col);
    tab_load_c = (tab_room_c < {3'b000, tab_step_c}) ? tab_room_c[PEND_W-1:0] : tab_step_c;
  end
`endif

  // Push/pop/issue decisions for this cycle; pending spaces win over new pops.
  always_comb begin
    push_c      = write_in && (count != CNT_W'(DEPTH));
    pop_c       = 1'b0;
    issue_c     = 1'b0;
    issue_ch_c  = head_c;
`ifdef DISPLAY_FIFO_TAB_EN
    pending_nxt = pending;
    if ((state == ST_IDLE) && disp_ready_in) begin
      if (pending != '0) begin
        issue_c     = 1'b1;
        issue_ch_c  = CH_SP;
        pending_nxt = PEND_W'(pending - 4'd1);
      end else if (count != '0) begin
        pop_c = 1'b1;
        if (head_c == CH_TAB) begin
          pending_nxt = tab_load_c;
        end else if (head_c != CH_NUL) begin
          issue_c = 1'b1;
        end
      end
    end
`else
    if ((state == ST_IDLE) && disp_ready_in && (count != '0)) begin
      pop_c   = 1'b1;
      issue_c = (head_c != CH_NUL);
    end
`endif
    count_nxt = CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      mem[wr_ptr] <= data_in[6:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      col            <= '0;
      state          <= ST_IDLE;
      full_out       <= 1'b0;
      empty_out      <= 1'b1;
      disp_data_out  <= '0;
      disp_write_out <= 1'b0;
`ifdef DISPLAY_FIFO_TAB_EN
      pending        <= '0;
`endif
    end else begin
      if (push_c) begin
        wr_ptr <= DEPTH_BITS'(wr_ptr + DEPTH_BITS'(1));
      end
      if (pop_c) begin
        rd_ptr <= DEPTH_BITS'(rd_ptr + DEPTH_BITS'(1));
      end
      count    <= count_nxt;
      full_out <= (count_nxt == CNT_W'(DEPTH));
`ifdef DISPLAY_FIFO_TAB_EN
      pending   <= pending_nxt;
      empty_out <= (count_nxt == '0) && (pending_nxt == '0);
`else
      empty_out <= (count_nxt == '0);
`endif

      // GAP covers the cycle in which the display has not yet dropped ready.
      case (state)
        ST_IDLE: begin
          if (issue_c) begin
            disp_data_out  <= issue_ch_c;
            disp_write_out <= 1'b1;
            col            <= col_after(col, issue_ch_c);
            state          <= ST_SEND;
          end
        end
        ST_SEND: begin
          disp_write_out <= 1'b0;
          state          <= ST_GAP;
        end
        ST_GAP: begin
          disp_write_out <= 1'b0;
          state          <= ST_IDLE;
        end
        default: begin
          disp_write_out <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_fifo.sv
// Scoreboard bench for display_fifo: a column-tracking character model fills the expected queue,
// a monitor pops it on every display strobe. Tab expectations follow DISPLAY_FIFO_TAB_EN.
module tb_display_fifo;

  localparam int unsigned DEPTH_BITS = 4;
  localparam int unsigned DEPTH      = 1 << DEPTH_BITS;
`ifdef DISPLAY_FIFO_TAB_EN
  localparam bit TAB = 1'b1;
`else
  localparam bit TAB = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       write_in;
  logic       full_out;
  logic       empty_out;
  logic [6:0] disp_data_out;
  logic       disp_write_out;
  logic       disp_ready_in;

  display_fifo #(.DEPTH_BITS(DEPTH_BITS)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .write_in      (write_in),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .disp_data_out (disp_data_out),
    .disp_write_out(disp_write_out),
    .disp_ready_in (disp_ready_in)
  );

  always #10 clk_in = ~clk_in;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] sb[$];
  int         model_col = 0;
  int         n_writes = 0;
  bit         hold = 1'b0;
  int         busy = 0;
  bit         prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the display should receive for one accepted CPU byte.
  function automatic void model_push(input logic [7:0] b);
    int c;
    c = int'(b & 8'h7f);
    if (c == 0) return;
`ifdef DISPLAY_FIFO_TAB_EN
    if (c == 9) begin
      int n;
      n = 8 - (model_col % 8);
      if (79 - model_col < n) n = 79 - model_col;
      for (int i = 0; i < n; i++) begin
        sb.push_back(7'h20);
        if (model_col < 79) model_col++;
      end
      return;
    end
`endif
    sb.push_back(7'(c));
    if (c == 13) model_col = 0;
    else if (c == 8) begin
      if (model_col > 0) model_col--;
    end else if (c != 10) begin
      if (model_col < 79) model_col++;
    end
  endfunction

  // Display model: busy for a random time after each strobe.
  initial begin
    disp_ready_in = 1'b1;
    forever begin
      @(negedge clk_in);
      if (disp_write_out) busy = $urandom_range(0, 5);
      else if (busy > 0) busy--;
      disp_ready_in = !hold && (busy == 0);
    end
  end

  // Monitor: every strobe must be a single-cycle pulse carrying the next expected character.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_wr = 1'b0;
      end else begin
        if (disp_write_out) begin
          n_writes++;
          chk("single_pulse", 32'(prev_wr), 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", disp_data_out, $time);
          end else begin
            chk("disp_data", 32'(disp_data_out), 32'(sb.pop_front()));
          end
        end
        prev_wr = disp_write_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit track);
    data_in  = b;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
    if (track) model_push(b);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    sb.delete();
    model_col = 0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (!((sb.size() == 0) && empty_out) && (k < 3000)) begin
      tick();
      k++;
    end
    chk(name, 32'(k < 3000), 32'd1);
    repeat (4) tick();
  endtask

  task automatic wait_writes(input int target);
    int k;
    k = 0;
    while ((n_writes < target) && (k < 500)) begin
      tick();
      k++;
    end
    chk("writes_reached", 32'(k < 500), 32'd1);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 8'h00;
      1: return 8'h09;
      2: return 8'h0D;
      3: return 8'h08;
      4: return 8'h0A;
      5: return 8'($urandom_range(128, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    int base;
    data_in  = 8'h00;
    write_in = 1'b0;
    rst_in   = 1'b1;
    repeat (2) tick();
    chk("rst_write", 32'(disp_write_out), 32'd0);
    chk("rst_data", 32'(disp_data_out), 32'h00);
    chk("rst_full", 32'(full_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    rst_in = 1'b0;
    sb.delete();
    model_col = 0;

    // Latency: push in cycle 0, strobe in cycle 2.
    push(8'h41, 1'b1);
    chk("lat_cycle1", 32'(disp_write_out), 32'd0);
    tick();
    chk("lat_cycle2", 32'(disp_write_out), 32'd1);
    chk("lat_data", 32'(disp_data_out), 32'h41);
    wait_drain("drain_first");
    chk("empty_after_first", 32'(empty_out), 32'd1);

    // Bit 7 stripped; NUL swallowed.
    push(8'hC1, 1'b1);
    wait_drain("drain_c1");
    base = n_writes;
    push(8'h00, 1'b1);
    chk("nul_not_empty", 32'(empty_out), 32'd0);
    repeat (4) tick();
    chk("nul_empty", 32'(empty_out), 32'd1);
    chk("nul_no_write", 32'(n_writes - base), 32'd0);

    // Fill with display stalled; 17th byte dropped.
    hold = 1'b1;
    repeat (3) tick();
    base = n_writes;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(8'(8'h30 + i), i < DEPTH);
      if (i == DEPTH - 2) chk("full_at_15", 32'(full_out), 32'd0);
      if (i == DEPTH - 1) chk("full_at_16", 32'(full_out), 32'd1);
    end
    chk("full_after_17", 32'(full_out), 32'd1);
    chk("stalled_no_write", 32'(n_writes - base), 32'd0);
    hold = 1'b0;
    wait_drain("drain_full");
    chk("full_writes", 32'(n_writes - base), 32'(DEPTH));
    chk("full_clear", 32'(full_out), 32'd0);

    // "AB" tab "C" from column 0.
    do_reset();
    base = n_writes;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h09, 1'b1);
    push(8'h43, 1'b1);
    wait_drain("drain_tab");
    chk("tab_writes", 32'(n_writes - base), TAB ? 32'd9 : 32'd4);

    // Tab near the right margin.
    do_reset();
    for (int i = 0; i < 77; i++) begin
      push(8'h78, 1'b1);
      if (i % 16 == 15) wait_drain("drain_col");
    end
    wait_drain("drain_col77");
    base = n_writes;
    push(8'h09, 1'b1);
    wait_drain("drain_tab77");
    chk("tab77_writes", 32'(n_writes - base), TAB ? 32'd2 : 32'd1);
    base = n_writes;
    push(8'h09, 1'b1);
    wait_drain("drain_tab79");
    chk("tab79_writes", 32'(n_writes - base), TAB ? 32'd0 : 32'd1);

    // Reset while spaces are still pending and the FIFO holds data.
    do_reset();
    base = n_writes;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    push(8'h09, 1'b1);
    wait_writes(base + 4);
    hold = 1'b1;
    repeat (4) tick();
    push(8'h44, 1'b0);
    push(8'h45, 1'b0);
    do_reset();
    chk("midrst_write", 32'(disp_write_out), 32'd0);
    chk("midrst_empty", 32'(empty_out), 32'd1);
    chk("midrst_full", 32'(full_out), 32'd0);
    hold = 1'b0;
    base = n_writes;
    repeat (3) tick();
    chk("midrst_quiet", 32'(n_writes - base), 32'd0);
    push(8'h09, 1'b1);
    wait_drain("drain_after_rst");
    chk("post_rst_tab", 32'(n_writes - base), TAB ? 32'd8 : 32'd1);

    // Random bursts, each fitting in an initially empty FIFO.
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) begin
        push(rand_byte(), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain("drain_rand");
    end
    chk("final_empty", 32'(empty_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
